// File: rtl/can_rx_fifo.sv
// Receive-side frame buffer for the CAN controller: ID/mask acceptance filters
// feeding a DEPTH-entry FIFO that is drained over the 32-bit peripheral bus.
module can_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int NFILT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frm_valid,
  input  logic [28:0] frm_id,
  input  logic        frm_ext,
  input  logic        frm_rtr,
  input  logic [3:0]  frm_dlc,
  input  logic [63:0] frm_data,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [28:0]      mem_id   [DEPTH];
  logic [3:0]       mem_dlc  [DEPTH];
  logic [1:0]       mem_fidx [DEPTH];
  logic [63:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] mem_ext, mem_rtr;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          ovf;
  logic [1:0]    ien;

  logic [NFILT-1:0] f_en, f_ext;
  logic [28:0]      f_id   [NFILT];
  logic [28:0]      f_mask [NFILT];

  logic wr_en, rd_en, ctrl_wr, pop_req, flush, clr_ovf;
  logic empty, full, any_en, hit_any, accept, do_pop, do_push, push_en, ovf_set;
  logic [1:0] hit_idx;
  logic unused_ok;

  assign unused_ok = data_in[29];

  assign wr_en   = (data_write_n == 2'b10);
  assign rd_en   = (data_read_n == 2'b10);
  assign ctrl_wr = wr_en && (address == 6'h10);
  assign pop_req = ctrl_wr & data_in[0];
  assign flush   = ctrl_wr & data_in[1];
  assign clr_ovf = ctrl_wr & data_in[2];

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // Descending scan so the lowest-index hit is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = 2'd0;
    for (int k = NFILT - 1; k >= 0; k--) begin
      if (f_en[k] && (f_ext[k] == frm_ext) && (((frm_id ^ f_id[k]) & f_mask[k]) == 29'd0)) begin
        hit_any = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  assign any_en  = |f_en;
  assign accept  = frm_valid & (~any_en | hit_any);
  assign do_pop  = pop_req & ~empty;
  assign do_push = accept & (~full | do_pop);
  assign push_en = do_push & ~flush;
  // A frame lost to a same-cycle flush is not counted as an overflow.
  assign ovf_set = accept & full & ~do_pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      ien    <= 2'b00;
      f_en   <= '0;
      f_ext  <= '0;
      for (int k = 0; k < NFILT; k++) begin
        f_id[k]   <= '0;
        f_mask[k] <= '0;
      end
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        level <= level + (AW+1)'(push_en) - (AW+1)'(do_pop);
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (ctrl_wr) ien <= data_in[9:8];
      for (int k = 0; k < NFILT; k++) begin
        if (wr_en && (address == 6'(32 + 8 * k))) begin
          f_en[k]  <= data_in[31];
          f_ext[k] <= data_in[30];
          f_id[k]  <= data_in[28:0];
        end
        if (wr_en && (address == 6'(36 + 8 * k))) f_mask[k] <= data_in[28:0];
      end
    end
  end

  // Frame storage carries no reset; empty/level gate every read of it.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_id[wr_ptr]   <= frm_id;
      mem_ext[wr_ptr]  <= frm_ext;
      mem_rtr[wr_ptr]  <= frm_rtr;
      mem_dlc[wr_ptr]  <= frm_dlc;
      mem_fidx[wr_ptr] <= hit_idx;
      mem_data[wr_ptr] <= frm_data;
    end
  end

  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (address)
        6'h00: if (!empty) data_out = {mem_ext[rd_ptr], mem_rtr[rd_ptr], 1'b0, mem_id[rd_ptr]};
        6'h04: begin
          if (empty) data_out = 32'h0000_0080;
          else       data_out = {8'd0, 8'(level), 6'd0, ovf, full, 2'b00,
                                 mem_fidx[rd_ptr], mem_dlc[rd_ptr]};
        end
        6'h08: if (!empty) data_out = mem_data[rd_ptr][31:0];
        6'h0C: if (!empty) data_out = mem_data[rd_ptr][63:32];
        6'h10: data_out = {22'd0, ien, 8'd0};
        default: begin
          for (int k = 0; k < NFILT; k++) begin
            if (address == 6'(32 + 8 * k)) data_out = {f_en[k], f_ext[k], 1'b0, f_id[k]};
            if (address == 6'(36 + 8 * k)) data_out = {3'd0, f_mask[k]};
          end
        end
      endcase
    end
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = (ien[0] & ~empty) | (ien[1] & ovf);

endmodule

// File: tb/tb_can_rx_fifo.sv
// Randomized and directed bench for can_rx_fifo against a queue-based model
// of the acceptance filters, FIFO and register map.
module tb_can_rx_fifo;
  localparam int DEPTH = 4;
  localparam int NFILT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frm_valid = 1'b0;
  logic [28:0] frm_id = '0;
  logic        frm_ext = 1'b0;
  logic        frm_rtr = 1'b0;
  logic [3:0]  frm_dlc = '0;
  logic [63:0] frm_data = '0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  can_rx_fifo #(.DEPTH(DEPTH), .NFILT(NFILT)) dut (
    .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_id(frm_id),
    .frm_ext(frm_ext), .frm_rtr(frm_rtr), .frm_dlc(frm_dlc), .frm_data(frm_data),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  typedef struct {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [1:0]  fidx;
  } frame_t;

  frame_t      q[$];
  logic        m_ovf;
  logic [1:0]  m_ien;
  logic [31:0] m_fid [4];
  logic [28:0] m_fmask [4];

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_ien = 2'b00;
    for (int k = 0; k < 4; k++) begin
      m_fid[k]   = '0;
      m_fmask[k] = '0;
    end
  endfunction

  // Applies the currently driven inputs to the model as of the coming edge.
  function automatic void model_update();
    bit     wr, ctrl, any_en, hit, acc, popped, was_full, ovf_set;
    int     idx, k;
    frame_t f;
    wr = (data_write_n == 2'b10);
    ctrl = wr && (address == 6'h10);
    any_en = 0; hit = 0; idx = 0; ovf_set = 0;
    for (int j = 0; j < NFILT; j++) begin
      if (m_fid[j][31]) any_en = 1;
      if (!hit && m_fid[j][31] && (m_fid[j][30] == frm_ext) &&
          (((frm_id ^ m_fid[j][28:0]) & m_fmask[j]) == 0)) begin
        hit = 1;
        idx = j;
      end
    end
    acc = frm_valid && (!any_en || hit);
    f.id = frm_id; f.ext = frm_ext; f.rtr = frm_rtr; f.dlc = frm_dlc;
    f.data = frm_data; f.fidx = 2'(idx);
    if (ctrl && data_in[1]) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      popped = ctrl && data_in[0] && (q.size() > 0);
      if (popped) void'(q.pop_front());
      if (acc) begin
        if (!was_full || popped) q.push_back(f);
        else ovf_set = 1;
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (ctrl && data_in[2]) m_ovf = 1'b0;
    if (ctrl) m_ien = data_in[9:8];
    if (wr && address >= 6'h20 && address[1:0] == 2'b00) begin
      k = int'(address[4:3]);
      if (k < NFILT) begin
        if (address[2]) m_fmask[k] = data_in[28:0];
        else m_fid[k] = data_in & 32'hDFFF_FFFF;
      end
    end
  endfunction

  function automatic logic [31:0] model_rd(input logic [5:0] a);
    logic [31:0] r;
    int k;
    r = '0;
    if (a == 6'h00) begin
      if (q.size() > 0) r = {q[0].ext, q[0].rtr, 1'b0, q[0].id};
    end else if (a == 6'h04) begin
      if (q.size() == 0) r = 32'h80;
      else r = {8'd0, 8'(q.size()), 6'd0, m_ovf, q.size() == DEPTH, 2'b00, q[0].fidx, q[0].dlc};
    end else if (a == 6'h08) begin
      if (q.size() > 0) r = q[0].data[31:0];
    end else if (a == 6'h0C) begin
      if (q.size() > 0) r = q[0].data[63:32];
    end else if (a == 6'h10) begin
      r = {22'd0, m_ien, 8'd0};
    end else if (a >= 6'h20 && a[1:0] == 2'b00) begin
      k = int'(a[4:3]);
      if (k < NFILT) r = a[2] ? {3'd0, m_fmask[k]} : m_fid[k];
    end
    return r;
  endfunction

  function automatic logic model_irq();
    return (m_ien[0] && q.size() > 0) || (m_ien[1] && m_ovf);
  endfunction

  task automatic set_frame(input logic [28:0] id, input logic ext, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] d);
    frm_valid = 1'b1; frm_id = id; frm_ext = ext; frm_rtr = rtr; frm_dlc = dlc; frm_data = d;
  endtask

  task automatic rand_frame(input bit small_ids);
    logic ext;
    logic [28:0] id;
    ext = 1'($urandom);
    if (small_ids) id = 29'($urandom_range(0, 7));
    else id = ext ? 29'($urandom) : 29'($urandom_range(0, 2047));
    set_frame(id, ext, 1'($urandom), 4'($urandom), {$urandom, $urandom});
  endtask

  task automatic wr_set(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    frm_valid = 1'b0;
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    address = a; data_read_n = 2'b10;
    #1 v = data_out;
    data_read_n = 2'b11;
    #1;
  endtask

  task automatic test_reset();
    logic [5:0]  addrs [9] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h20, 6'h24, 6'h28, 6'h2C};
    logic [31:0] v;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (user_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", user_interrupt); end
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL data_ready got=%b exp=1", data_ready); end
    checks++;
    if (data_out !== 32'd0) begin errors++; $display("FAIL idle_data_out got=%h exp=0", data_out); end
    for (int i = 0; i < 9; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== ((addrs[i] == 6'h04) ? 32'h80 : 32'h0)) begin
        errors++; $display("FAIL reset_reg_%h got=%h exp=%h", addrs[i], v, (addrs[i] == 6'h04) ? 32'h80 : 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] v;
    set_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    step();
    rd(6'h00, v); checks++;
    if (v !== 32'h0000_0123) begin errors++; $display("FAIL basic_id got=%h exp=00000123", v); end
    rd(6'h04, v); checks++;
    if (v !== 32'h0001_0002) begin errors++; $display("FAIL basic_stat got=%h exp=00010002", v); end
    rd(6'h08, v); checks++;
    if (v !== 32'h0000_BEEF) begin errors++; $display("FAIL basic_data0 got=%h exp=0000beef", v); end
    wr_set(6'h10, 32'h1);
    step();
    rd(6'h04, v); checks++;
    if (v !== 32'h0000_0080) begin errors++; $display("FAIL basic_pop_stat got=%h exp=00000080", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      rand_frame(1'b0);
      step();
    end
    rd(6'h04, v); checks++;
    if (v[9] !== 1'b1 || v[23:16] !== 8'd4 || v !== model_rd(6'h04)) begin
      errors++; $display("FAIL ovf_stat got=%h exp=%h", v, model_rd(6'h04));
    end
    wr_set(6'h10, 32'h200);
    step();
    checks++;
    if (user_interrupt !== 1'b1) begin errors++; $display("FAIL ovf_irq_on got=%b exp=1", user_interrupt); end
    wr_set(6'h10, 32'h204);
    step();
    checks++;
    if (user_interrupt !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear got=%b exp=0", user_interrupt); end
    for (int i = 0; i < 4; i++) begin
      rd(6'h00, v); checks++;
      if (v !== model_rd(6'h00)) begin errors++; $display("FAIL ovf_order_id%0d got=%h exp=%h", i, v, model_rd(6'h00)); end
      rd(6'h0C, v); checks++;
      if (v !== model_rd(6'h0C)) begin errors++; $display("FAIL ovf_order_d1_%0d got=%h exp=%h", i, v, model_rd(6'h0C)); end
      wr_set(6'h10, 32'h1);
      step();
    end
  endtask

  task automatic test_filter();
    logic [31:0] v;
    wr_set(6'h28, 32'hDABC_DE00); step();
    wr_set(6'h2C, 32'h1FFF_FF00); step();
    set_frame(29'h1ABCDE42, 1'b1, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF); step();
    set_frame(29'h1ABCDF42, 1'b1, 1'b0, 4'd1, 64'h1); step();
    set_frame(29'h042, 1'b0, 1'b0, 4'd1, 64'h2); step();
    rd(6'h04, v); checks++;
    if (v !== 32'h0001_0018) begin errors++; $display("FAIL filt_stat got=%h exp=00010018", v); end
    rd(6'h00, v); checks++;
    if (v !== 32'h9ABC_DE42) begin errors++; $display("FAIL filt_id got=%h exp=9abcde42", v); end
    rd(6'h28, v); checks++;
    if (v !== 32'hDABC_DE00) begin errors++; $display("FAIL filt_reg got=%h exp=dabcde00", v); end
    wr_set(6'h28, 32'h0); step();
    wr_set(6'h10, 32'h1); step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      rand_frame(1'b0);
      step();
    end
    rand_frame(1'b0);
    wr_set(6'h10, 32'h1);
    step();
    rd(6'h04, v); checks++;
    if (v[23:16] !== 8'd4 || v[9] !== 1'b0 || v !== model_rd(6'h04)) begin
      errors++; $display("FAIL b2b_full_stat got=%h exp=%h", v, model_rd(6'h04));
    end
    for (int i = 0; i < 4; i++) begin
      rd(6'h08, v); checks++;
      if (v !== model_rd(6'h08)) begin errors++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, v, model_rd(6'h08)); end
      wr_set(6'h10, 32'h1);
      step();
    end
    wr_set(6'h10, 32'h1);
    step();
    rd(6'h04, v); checks++;
    if (v !== 32'h80) begin errors++; $display("FAIL b2b_pop_empty got=%h exp=00000080", v); end
  endtask

  task automatic test_flush();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      rand_frame(1'b0);
      step();
    end
    rand_frame(1'b0);
    wr_set(6'h10, 32'h3);
    step();
    rd(6'h04, v); checks++;
    if (v !== 32'h80) begin errors++; $display("FAIL flush_stat got=%h exp=00000080", v); end
    for (int i = 0; i < 6; i++) begin
      rand_frame(1'b0);
      step();
      rd(6'h00, v); checks++;
      if (v !== model_rd(6'h00) || q.size() != 1) begin
        errors++; $display("FAIL wrap_id%0d got=%h exp=%h", i, v, model_rd(6'h00));
      end
      wr_set(6'h10, 32'h1);
      step();
    end
  endtask

  task automatic test_random();
    logic [5:0]  addrs [5] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
    logic [31:0] v;
    int sel;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) rand_frame(1'b1);
      sel = $urandom_range(0, 7);
      if (sel < 3) begin
        wr_set(6'h10, {22'd0, 2'($urandom), 5'd0, 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 15) == 0), 1'($urandom)});
      end else if (sel == 3) begin
        wr_set(6'(32 + 8 * $urandom_range(0, 3)),
               {1'($urandom), 1'($urandom), 1'($urandom), 26'd0, 3'($urandom)});
      end else if (sel == 4) begin
        wr_set(6'(36 + 8 * $urandom_range(0, 3)), $urandom & 32'hE000_0007);
      end
      step();
      for (int i = 0; i < 5; i++) begin
        rd(addrs[i], v); checks++;
        if (v !== model_rd(addrs[i])) begin
          errors++; $display("FAIL rand_reg_%h cyc%0d got=%h exp=%h", addrs[i], n, v, model_rd(addrs[i]));
        end
      end
      rd(6'(32 + 4 * $urandom_range(0, 7)), v); checks++;
      if (v !== model_rd(address)) begin
        errors++; $display("FAIL rand_filt_%h got=%h exp=%h", address, v, model_rd(address));
      end
      checks++;
      if (user_interrupt !== model_irq()) begin
        errors++; $display("FAIL rand_irq cyc%0d got=%b exp=%b", n, user_interrupt, model_irq());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0]  addrs [6] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h20, 6'h24};
    logic [31:0] v;
    for (int k = 0; k < NFILT; k++) begin
      wr_set(6'(32 + 8 * k), 32'h0); step();
    end
    wr_set(6'h10, 32'h6); step();
    for (int i = 0; i < 3; i++) begin
      rand_frame(1'b0); step();
    end
    wr_set(6'h10, 32'h100); step();
    wr_set(6'h20, 32'h8000_0000); step();
    checks++;
    if (user_interrupt !== 1'b1) begin errors++; $display("FAIL mid_irq_before got=%b exp=1", user_interrupt); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (user_interrupt !== 1'b0) begin errors++; $display("FAIL mid_irq_reset got=%b exp=0", user_interrupt); end
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v); checks++;
      if (v !== ((addrs[i] == 6'h04) ? 32'h80 : 32'h0)) begin
        errors++; $display("FAIL mid_reg_%h got=%h exp=%h", addrs[i], v, (addrs[i] == 6'h04) ? 32'h80 : 32'h0);
      end
    end
    set_frame(29'h55, 1'b0, 1'b0, 4'd1, 64'h1);
    @(posedge clk);
    #1 frm_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rd(6'h04, v); checks++;
    if (v !== 32'h80) begin errors++; $display("FAIL mid_lost_frame got=%h exp=00000080", v); end
    set_frame(29'h1234567, 1'b1, 1'b0, 4'd3, 64'h77);
    step();
    rd(6'h04, v); checks++;
    if (v !== 32'h0001_0003) begin errors++; $display("FAIL mid_filters_off got=%h exp=00010003", v); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_filter();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_rx_fifo.md
# can_rx_fifo

Parametrised receive-side buffer for the CAN controller: accepts completed frames from the CAN receiver, passes them through `NFILT` programmable ID/mask acceptance filters, and stores accepted frames in a `DEPTH`-entry FIFO read by TinyQV over the standard 32-bit peripheral bus. It replaces the single-frame `rx_id`/`dlc`/`rdata` holding registers and the `frmav`/`ovwr` flags. Software can therefore drain bursts of frames without loss and without seeing traffic it has filtered out.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..128.
- `NFILT`, 2: acceptance filters, 1..4.
- `clk` input 1: system clock (64 MHz nominal).
- `rst_n` input 1: asynchronous, active-low reset.
- `frm_valid` input 1: one-cycle pulse, frame received with good CRC.
- `frm_id` input 29: identifier; standard IDs in [10:0], upper bits 0.
- `frm_ext` input 1: extended frame.
- `frm_rtr` input 1: remote frame.
- `frm_dlc` input 4: data length code.
- `frm_data` input 64: payload; byte 0 in [7:0], byte 7 in [63:56].
- `address` input 6: register byte address.
- `data_in` input 32: write data.
- `data_write_n` input 2: 11 none, 10 = 32-bit write; other codes ignored.
- `data_read_n` input 2: 11 none, 10 = 32-bit read; other codes return 0.
- `data_out` output 32: read data, combinational, 0 when not reading.
- `data_ready` output 1: tied 1.
- `user_interrupt` output 1: level interrupt.

## Operation
- Register map (32-bit only):
  - 0x00 HEAD_ID (R): `{ext, rtr, 1'b0, id[28:0]}`.
  - 0x04 HEAD_STAT (R): [3:0] dlc, [5:4] filter index hit, [7] empty, [8] full, [9] ovf, [23:16] level.
  - 0x08 HEAD_DATA0 (R): bytes 3..0.
  - 0x0C HEAD_DATA1 (R): bytes 7..4.
  - 0x10 CTRL (W): bit0 pop, bit1 flush, bit2 clear ovf, [9:8] irq enable {ovf, not-empty}. R: [9:8] enables, other bits 0.
  - 0x20+8k FILT_ID k (R/W): [31] enable, [30] required ext, [28:0] id.
  - 0x24+8k FILT_MASK k (R/W): [28:0] mask, where 1 = bit compared.
  - Unmapped addresses or filters k ≥ NFILT read 0; writes to them are ignored.
- Acceptance:
  - Filter k hits when it is enabled, `frm_ext` equals [30], and `((frm_id ^ id) & mask) == 0`.
  - The lowest-index hit is stored as the filter index.
  - If no filter is enabled, every frame is accepted with index 0.
  - A frame with no hit while filters are enabled is dropped silently.
- Push: an accepted frame on `frm_valid` is written at the write pointer.
  - If the FIFO is full and no pop occurs the same cycle, the new frame is dropped, ovf is set, and the stored contents are unchanged.
- Pop: a CTRL write with bit0=1 advances the read pointer. Pop on empty is ignored.
- Flush: a CTRL write with bit1=1 zeroes both pointers and the level. It takes priority over push and pop in the same cycle. ovf is unaffected unless bit2 is also set.
- Clearing ovf with bit2=1 in the same cycle as a new overflow leaves ovf = 1 (set wins).
- Reading HEAD_* while empty returns 0 in all fields except empty (bit7).
- `user_interrupt` = (ien[0] & ~empty) | (ien[1] & ovf).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The level is log2(DEPTH)+1 bits, saturating at DEPTH by construction.

## Timing
- Reset state: pointers, level, ovf and ien = 0; filter regs = 0 (all disabled, so all frames accepted); `data_out` = 0; `user_interrupt` = 0.
- Filter evaluation is combinational in the `frm_valid` cycle. The entry, level and flags update at that clock edge, so the head is readable on the next cycle.
- Register writes take effect at the write-cycle edge. A frame arriving in the same cycle as a filter write is evaluated against the old filter values.
- Simultaneous push and pop:
  - Not full: both happen and the level is unchanged.
  - Full: both happen, the frame is accepted, ovf is not set.
  - Empty: the pop is ignored and the push is stored.
- A reads is zero-wait; HEAD_* reflects state as of the previous edge.
- Reset asserted mid-operation clears all state immediately and asynchronously. A `frm_valid` during reset is lost.

## Test plan
- Reset, then push a standard frame with id=0x123, dlc=2, data=0xBEEF: HEAD_ID=0x00000123, HEAD_STAT=0x00010002, HEAD_DATA0=0x0000BEEF. Pop: STAT bit7=1, level 0.
- DEPTH=4: push 5 accepted frames with no pop. The first 4 are retained in order, ovf=1, level=4. With ien=10, irq=1. Clearing ovf drops irq.
- Filter 1: enable, ext=1, id=0x1ABCDE00, mask=0x1FFFFF00. Push ext id 0x1ABCDE42 (stored, index 1), ext id 0x1ABCDF42 (dropped), standard id 0x042 (dropped). Level = 1.
- Full FIFO plus push and pop in the same cycle: level stays 4, new frame at the tail, ovf=0. Pop on empty: level stays 0.
- Push 3 frames, then write CTRL=0x3 together with a `frm_valid`: level=0 and empty=1 afterwards, and wrap-around works on a further 6 push/pop pairs.
- Reset asserted with level=3 and ien=01: on reset assert, irq=0, all registers read back as their reset values, and filters are disabled.
